// File: rtl/ser2par_en.sv
// Serial-to-parallel deserializer: one bit per enabled clk edge, registered word plus one-cycle valid.
// Optional macro SER2PAR_PARITY_EN appends an even-parity bit to every frame and checks it.
module ser2par_en #(
  parameter int WIDTH     = 8,
  parameter int CW        = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             d,
  input  logic             clr,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic [CW-1:0]    cnt,
  output logic             busy,
  output logic             parity_err
);

`ifdef SER2PAR_PARITY_EN
  // The last accepted bit of a frame is the parity bit, which never enters the shift register.
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word_reg;
  logic [CW-1:0]    cnt_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             last_bit;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg_reg[WIDTH-2:0], d};
    end else begin : g_lsb
      assign shifted = {d, shreg_reg[WIDTH-1:1]};
    end
  endgenerate

  assign last_bit = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else if (clr) begin
      shreg_reg <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else if (en) begin
      if (last_bit) begin
        cnt_reg   <= '0;
        busy_reg  <= 1'b0;
        valid_reg <= 1'b1;
        shreg_reg <= '0;
`ifdef SER2PAR_PARITY_EN
        word_reg  <= shreg_reg;
`else
        word_reg  <= shifted;
`endif
      end else begin
        cnt_reg   <= cnt_reg + 1'b1;
        busy_reg  <= 1'b1;
        valid_reg <= 1'b0;
        shreg_reg <= shifted;
      end
    end else begin
      valid_reg <= 1'b0;
    end
  end

`ifdef SER2PAR_PARITY_EN
  logic perr_reg;

  // Updated only on frame completion so it survives clr until the next word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perr_reg <= 1'b0;
    end else if (!clr && en && last_bit) begin
      perr_reg <= (^shreg_reg) ^ d;
    end
  end

  assign parity_err = perr_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign word  = word_reg;
  assign valid = valid_reg;
  assign cnt   = cnt_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_ser2par_en.sv
// Bench for ser2par_en: MSB-first and LSB-first instances share one stimulus stream.
// Expected words are queued when the closing bit is driven and checked when valid must appear.
module tb_ser2par_en;
  localparam int WIDTH = 8;
`ifdef SER2PAR_PARITY_EN
  localparam int PAR = 1;
  localparam int CW  = 4;
`else
  localparam int PAR = 0;
  localparam int CW  = 3;
`endif
  localparam int FRAME = WIDTH + PAR;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b0;
  logic d = 1'b0;
  logic clr = 1'b0;

  logic [WIDTH-1:0] word_m, word_l;
  logic             valid_m, valid_l, busy_m, busy_l, perr_m, perr_l;
  logic [CW-1:0]    cnt_m, cnt_l;

  ser2par_en #(.WIDTH(WIDTH), .CW(CW), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .en(en), .d(d), .clr(clr),
    .word(word_m), .valid(valid_m), .cnt(cnt_m), .busy(busy_m), .parity_err(perr_m)
  );

  ser2par_en #(.WIDTH(WIDTH), .CW(CW), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .en(en), .d(d), .clr(clr),
    .word(word_l), .valid(valid_l), .cnt(cnt_l), .busy(busy_l), .parity_err(perr_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned      cyc;
    logic [WIDTH-1:0] wm;
    logic [WIDTH-1:0] wl;
    logic             perr;
  } exp_t;

  exp_t q[$];
  int unsigned cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  // Reference state, updated just after each clock edge.
  int               m_cnt = 0;
  logic             m_bits [0:WIDTH];
  logic [WIDTH-1:0] m_wm = '0;
  logic [WIDTH-1:0] m_wl = '0;
  logic             m_perr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic b, input logic c);
    logic             p;
    exp_t             x;
    reset_n = r; en = e; d = b; clr = c;
    @(posedge clk);
    #1;
    if (!r) begin
      m_cnt = 0; m_wm = '0; m_wl = '0; m_perr = 1'b0;
    end else if (c) begin
      m_cnt = 0;
    end else if (e) begin
      m_bits[m_cnt] = b;
      m_cnt++;
      if (m_cnt == FRAME) begin
        p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          m_wm[WIDTH-1-i] = m_bits[i];
          m_wl[i]         = m_bits[i];
          p               = p ^ m_bits[i];
        end
        if (PAR != 0) m_perr = p ^ m_bits[WIDTH];
        x.cyc = cyc; x.wm = m_wm; x.wl = m_wl; x.perr = m_perr;
        q.push_back(x);
        m_cnt = 0;
      end
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, v[i], 1'b0);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] v, input logic flip);
    send_bits(32'(v), WIDTH);
    if (PAR != 0) step(1'b1, 1'b1, (^v) ^ flip, 1'b0);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      bit   exp_v;
      exp_t x;
      exp_v = (q.size() > 0) && (q[0].cyc == cyc);
      check("valid_msb", 32'(valid_m), 32'(exp_v));
      check("valid_lsb", 32'(valid_l), 32'(exp_v));
      if (exp_v) begin
        x = q.pop_front();
        check("sb_word_msb", 32'(word_m), 32'(x.wm));
        check("sb_word_lsb", 32'(word_l), 32'(x.wl));
        check("sb_perr", 32'(perr_m), 32'(x.perr));
        $display("word cycle %0d: msb=%02h lsb=%02h parity_err=%0b", cyc, word_m, word_l, perr_m);
      end
      check("hold_word_msb", 32'(word_m), 32'(m_wm));
      check("hold_word_lsb", 32'(word_l), 32'(m_wl));
      check("hold_perr_lsb", 32'(perr_l), 32'(m_perr));
      check("cnt_msb", 32'(cnt_m), 32'(m_cnt));
      check("cnt_lsb", 32'(cnt_l), 32'(m_cnt));
      check("busy_msb", 32'(busy_m), 32'(m_cnt != 0));
      check("busy_lsb", 32'(busy_l), 32'(m_cnt != 0));
    end
  end

  initial begin
    step(1'b0, 1'b1, 1'b1, 1'b1);
    checking = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // A5 sent as 1,0,1,0,0,1,0,1: A5 in both bit orders.
    send_frame(8'hA5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Gap of three idle cycles with d toggling inside a word.
    send_bits(32'hA, 4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, i[0], 1'b0);
    send_bits(32'h5, 4);
    if (PAR != 0) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Abort a partial word with clr (en high too: clr wins), then send 3C.
    send_bits(32'h15, 5);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0);

    // Back-to-back words with en held high.
    send_frame(8'hFF, 1'b0);
    send_frame(8'h00, 1'b0);

    // Reset in the middle of a word, then a clean word.
    send_bits(32'h5, 3);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(8'h96, 1'b0);

    // Bad parity (plain extra word without parity), then clr must not disturb it.
    send_frame(8'hA5, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Random words with random idle gaps between bits.
    for (int k = 0; k < 6; k++) begin
      logic [WIDTH-1:0] v;
      v = WIDTH'($urandom);
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, 1'($urandom), 1'b0);
        step(1'b1, 1'b1, v[i], 1'b0);
      end
      if (PAR != 0) step(1'b1, 1'b1, (^v) ^ 1'($urandom_range(0, 1)), 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
